// File: rtl/uart_matmul_engine.sv
// N x N matrix-multiply engine driven by a byte command stream (01 load A, 02 load B, 03 compute).
// Optional build macro MATMUL_SIGNED_EN: two's-complement operands and sign-extended results.
module uart_matmul_engine #(
    parameter int unsigned N         = 3,
    parameter int unsigned DATAWIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned ACCW      = 2 * DATAWIDTH + $clog2(N);
    localparam int unsigned OUT_BYTES = (ACCW + 7) / 8;
    localparam int unsigned OUTW      = OUT_BYTES * 8;
    localparam int unsigned NN        = N * N;
    localparam int unsigned IW        = $clog2(N);
    localparam int unsigned LW        = $clog2(NN);
    localparam int unsigned BW        = $clog2(OUT_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_CALC, S_SEND, S_WAIT_HI, S_WAIT_LO, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          ld_q, ld_d;
    logic [IW-1:0]          i_q, i_d, j_q, j_d, k_q, k_d;
    logic [BW-1:0]          b_q, b_d;
    logic [ACCW-1:0]        acc_q, acc_d, res_q, res_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic                   busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [DATAWIDTH-1:0]   a_q [NN];
    logic [DATAWIDTH-1:0]   b_mat_q [NN];
    logic                   a_we, b_we;

    logic [DATAWIDTH-1:0]   a_el, b_el;
    logic [ACCW-1:0]        prod, sum;
    logic [OUTW-1:0]        res_ext;

    // Operand/result widening: sign- or zero-extension depending on the build.
    function automatic logic [ACCW-1:0] ext_op(input logic [DATAWIDTH-1:0] v);
`ifdef MATMUL_SIGNED_EN
        return ACCW'($signed(v));
`else
        return ACCW'(v);
`endif
    endfunction

    function automatic logic [OUTW-1:0] ext_res(input logic [ACCW-1:0] v);
`ifdef MATMUL_SIGNED_EN
        return OUTW'($signed(v));
`else
        return OUTW'(v);
`endif
    endfunction

    assign a_el    = a_q[LW'(32'(i_q) * N + 32'(k_q))];
    assign b_el    = b_mat_q[LW'(32'(k_q) * N + 32'(j_q))];
    assign prod    = ext_op(a_el) * ext_op(b_el);
    assign sum     = acc_q + prod;
    assign res_ext = ext_res(res_q);

    always_comb begin
        state_d    = state_q;
        ld_d       = ld_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        b_d        = b_q;
        acc_d      = acc_q;
        res_d      = res_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        a_we       = 1'b0;
        b_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        8'h01: begin state_d = S_LOAD_A; ld_d = '0; end
                        8'h02: begin state_d = S_LOAD_B; ld_d = '0; end
                        8'h03: begin
                            state_d = S_CALC;
                            i_d     = '0;
                            j_d     = '0;
                            k_d     = '0;
                            acc_d   = '0;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                if (rx_valid) begin
                    a_we = (state_q == S_LOAD_A);
                    b_we = (state_q == S_LOAD_B);
                    if (ld_q == LW'(NN - 1)) begin
                        ld_d    = '0;
                        state_d = S_IDLE;
                    end else begin
                        ld_d = ld_q + LW'(1);
                    end
                end
            end
            S_CALC: begin
                if (k_q == IW'(N - 1)) begin
                    res_d   = sum;
                    acc_d   = '0;
                    k_d     = '0;
                    b_d     = BW'(OUT_BYTES - 1);
                    state_d = S_SEND;
                end else begin
                    acc_d = sum;
                    k_d   = k_q + IW'(1);
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_data_d  = 8'(res_ext >> (32'(b_q) * 8));
                    tx_start_d = 1'b1;
                    state_d    = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (tx_busy) state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                // Byte done: next byte of this element, next element, or finish.
                if (!tx_busy) begin
                    if (b_q != '0) begin
                        b_d     = b_q - BW'(1);
                        state_d = S_SEND;
                    end else if (j_q != IW'(N - 1)) begin
                        j_d     = j_q + IW'(1);
                        state_d = S_CALC;
                    end else if (i_q != IW'(N - 1)) begin
                        j_d     = '0;
                        i_d     = i_q + IW'(1);
                        state_d = S_CALC;
                    end else begin
                        j_d     = '0;
                        i_d     = '0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (rx_valid && (state_q inside {S_CALC, S_SEND, S_WAIT_HI, S_WAIT_LO, S_DONE}))
            err_d = 1'b1;
    end

    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ld_q       <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            res_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int unsigned e = 0; e < NN; e++) begin
                a_q[e]     <= '0;
                b_mat_q[e] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ld_q       <= ld_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            res_q      <= res_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            if (a_we) a_q[ld_q]     <= rx_data[DATAWIDTH-1:0];
            if (b_we) b_mat_q[ld_q] <= rx_data[DATAWIDTH-1:0];
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_uart_matmul_engine.sv
// Randomised bench for uart_matmul_engine: byte-level reference model plus a busy-holding transmitter.
module tb_uart_matmul_engine;

    localparam int unsigned N     = 3;
    localparam int unsigned DW    = 8;
    localparam int unsigned ACCW  = 2 * DW + $clog2(N);
    localparam int unsigned OB    = (ACCW + 7) / 8;
    localparam int unsigned NN    = N * N;
    localparam int          LIMIT = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start, busy, done, err;

    uart_matmul_engine #(.N(N), .DATAWIDTH(DW)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int err_cnt = 0, done_cnt = 0;
    int busy_len = 20, busy_cnt = 0;
    int start_busy_viol = 0, data_viol = 0;
    logic [7:0] held = 8'h00;
    logic [7:0] cap[$];
    logic [7:0] expq[$];
    logic [7:0] vals[NN];
    int ma[NN], mb[NN];

    // Transmitter model: one byte per tx_start, busy held for busy_len cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy  <= 1'b0;
            busy_cnt <= 0;
        end else begin
            if (err)  err_cnt  <= err_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (tx_start) begin
                if (tx_busy) start_busy_viol <= start_busy_viol + 1;
                cap.push_back(tx_data);
                held     <= tx_data;
                tx_busy  <= 1'b1;
                busy_cnt <= busy_len;
            end else if (tx_busy) begin
                if (tx_data != held) data_viol <= data_viol + 1;
                if (busy_cnt <= 1) tx_busy <= 1'b0;
                else busy_cnt <= busy_cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sval(input int v);
`ifdef MATMUL_SIGNED_EN
        if (v >= 2 ** (DW - 1)) return longint'(v) - longint'(2 ** DW);
`endif
        return longint'(v);
    endfunction

    // Expected link stream: every C element, MSB byte first, in row-major order.
    task automatic build_exp();
        longint s;
        expq.delete();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++)
                    s += sval(ma[i*N+k]) * sval(mb[k*N+j]);
                for (int b = OB - 1; b >= 0; b--)
                    expq.push_back(8'((s >> (8 * b)) & 64'hFF));
            end
    endtask

    task automatic send_byte(input logic [7:0] v);
        @(negedge clk);
        rx_data  = v;
        rx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic load(input bit is_b);
        send_byte(is_b ? 8'h02 : 8'h01);
        check(is_b ? "busy_in_load_b" : "busy_in_load_a", busy, 1);
        for (int q = 0; q < NN; q++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(vals[q]);
            if (is_b) mb[q] = int'(vals[q]) & ((1 << DW) - 1);
            else      ma[q] = int'(vals[q]) & ((1 << DW) - 1);
        end
        check("idle_after_load", busy, 0);
    endtask

    task automatic fill_rand();
        for (int q = 0; q < NN; q++) vals[q] = 8'($urandom);
    endtask

    // Issue compute, optionally inject a stray byte in CALC, and compare the whole stream.
    task automatic run_calc(input bit inject, input int blen);
        int c, first, d0, e0;
        busy_len = blen;
        build_exp();
        cap.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'h03);
        c = 0;
        first = -1;
        while (done_cnt == d0 && c < LIMIT) begin
            if (inject && c == 1) begin
                rx_data  = 8'h55;
                rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
            @(posedge clk);
            c++;
            @(negedge clk);
            if (first < 0 && tx_start) first = c;
        end
        rx_valid = 1'b0;
        check("calc_timeout", longint'(c < LIMIT), 1);
        check("first_start_latency", first, N + 1);
        check("done_pulses", done_cnt - d0, 1);
        check("err_pulses", err_cnt - e0, inject ? 1 : 0);
        check("idle_after_done", busy, 0);
        check("byte_count", cap.size(), NN * OB);
        for (int q = 0; q < cap.size() && q < expq.size(); q++)
            check($sformatf("byte%0d", q), cap[q], expq[q]);
    endtask

    initial begin
        int e0, w;
        repeat (3) @(negedge clk);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        for (int q = 0; q < NN; q++) begin ma[q] = 0; mb[q] = 0; end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Deterministic ramp matrices.
        for (int q = 0; q < NN; q++) vals[q] = 8'(q + 1);
        load(1'b0);
        for (int q = 0; q < NN; q++) vals[q] = 8'(q + 5);
        load(1'b1);
        run_calc(1'b0, 20);

        // Unknown command, then a normal load that reuses the old B.
        e0 = err_cnt;
        send_byte(8'h7F);
        repeat (2) @(negedge clk);
        check("bad_cmd_err", err_cnt - e0, 1);
        check("bad_cmd_busy", busy, 0);
        fill_rand();
        load(1'b0);
        run_calc(1'b0, 20);

        // Stray byte during CALC must not disturb results.
        run_calc(1'b1, 3);

        // All-ones operands.
        for (int q = 0; q < NN; q++) vals[q] = 8'hFF;
        load(1'b0);
        load(1'b1);
        run_calc(1'b0, 1);
`ifdef MATMUL_SIGNED_EN
        check("all_ff_elem", {cap[0], cap[1], cap[2]}, 3);
`else
        check("all_ff_elem", {cap[0], cap[1], cap[2]}, 195075);
`endif

        // Reset while the second element is in flight.
        fill_rand();
        load(1'b0);
        fill_rand();
        load(1'b1);
        busy_len = 20;
        cap.delete();
        send_byte(8'h03);
        w = 0;
        while (cap.size() < OB + 1 && w < LIMIT) begin
            @(negedge clk);
            w++;
        end
        check("reach_elem2_timeout", longint'(w < LIMIT), 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_tx_data", tx_data, 0);
        check("midrst_tx_start", tx_start, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err, 0);
        for (int q = 0; q < NN; q++) begin ma[q] = 0; mb[q] = 0; end
        cap.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("no_start_after_rst", cap.size(), 0);
        check("idle_after_rst", busy, 0);
        fill_rand();
        load(1'b1);
        run_calc(1'b0, 20);

        // Random matrices and transmitter speeds.
        for (int t = 0; t < 4; t++) begin
            fill_rand();
            load(1'b0);
            fill_rand();
            load(1'b1);
            run_calc(1'($urandom_range(0, 1)), int'($urandom_range(1, 8)));
        end

        check("start_while_busy", start_busy_viol, 0);
        check("tx_data_stable", data_viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_matmul_engine.md
Name: uart_matmul_engine

Overview:
Parametrised N×N matrix-multiply engine with a byte-stream command protocol. It sits between a uart_receiver (byte + valid) and a uart_transmitter (byte + start/busy). Bytes received over the link load operand matrices A and B. A compute command runs a sequential MAC over C = A·B, then streams every element of C back out, MSB byte first. It is the generalised successor to the fixed 3×3 UART matrix block, with a defined protocol, error reporting and a transmitter handshake.

Parameters:
N, 3, matrix dimension (2..8)
DATAWIDTH, 8, operand element width (1..8); taken from the low DATAWIDTH bits of each received byte
ACCW, 2*DATAWIDTH+$clog2(N), accumulator/result width (derived, localparam)
OUT_BYTES, (ACCW+7)/8, bytes transmitted per result element (derived, localparam)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
rx_data  input  8  byte from receiver
rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle
tx_data  output  8  byte to transmitter; held stable from tx_start until busy falls
tx_start  output  1  one-cycle start pulse to transmitter
tx_busy  input  1  transmitter busy
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the last byte of C has been transmitted
err  output  1  one-cycle pulse on protocol error

Behaviour:
- Reset (async, rst=1): state=IDLE; all counters, A, B and the accumulator cleared to 0. Outputs tx_data=0, tx_start=0, busy=0, done=0, err=0. A reset mid-operation aborts immediately; no further tx_start is issued.
- States: IDLE, LOAD_A, LOAD_B, CALC, SEND, WAIT_HI, WAIT_LO, DONE.
- IDLE, on rx_valid, decodes rx_data as a command:
  - 0x01 -> LOAD_A
  - 0x02 -> LOAD_B
  - 0x03 -> CALC, with i=j=k=0 and acc=0
  - any other byte -> err pulse on the next cycle; stay in IDLE.
- LOAD_A / LOAD_B: each rx_valid stores the byte into element [r][c], row-major, with c incrementing first. After the N*N-th byte, return to IDLE. There is no timeout. Matrices persist across commands, so A is reusable with a new B.
- CALC: one MAC per cycle, acc += A[i][k]*B[k][j], ACCW-bit unsigned. Arithmetic cannot overflow by construction.
  - At k=N-1, the final sum is latched into the send register and the state moves to SEND.
  - Per-element latency from CALC entry to first tx_start: N+1 cycles.
- SEND: with tx_busy=0, drive byte b (b = OUT_BYTES-1 down to 0) of the result, zero-extended to OUT_BYTES*8, and pulse tx_start for one cycle. Then go to WAIT_HI.
- WAIT_HI: wait for tx_busy=1, then go to WAIT_LO. WAIT_LO: wait for tx_busy=0.
  - If bytes remain for this element -> SEND.
  - Else advance j, then i. If elements remain -> CALC (acc=0, k=0); otherwise -> DONE.
- DONE: pulse done for one cycle, then go to IDLE.
- rx_valid in CALC/SEND/WAIT_HI/WAIT_LO/DONE: the byte is discarded and err pulses. State is unaffected.
- rx_valid and a state transition in the same cycle: in a load state, the byte is taken by that state.
- Element order on the link: C[0][0], C[0][1], …, C[N-1][N-1]; total N*N*OUT_BYTES bytes.

Optional Feature:
MATMUL_SIGNED_EN
- Defined: operands are two's-complement DATAWIDTH-bit values, and products/accumulation are signed. Results are sign-extended (not zero-extended) to OUT_BYTES*8 bits before transmission.
- Undefined: all arithmetic is unsigned and results are zero-extended.
- The protocol and timing are identical in both builds.

Test Plan:
- N=2, DW=8: send 01,1,2,3,4 then 02,5,6,7,8 then 03. The tx byte stream (OUT_BYTES=3) must be 00 00 13, 00 00 16, 00 00 2B, 00 00 32, followed by one done pulse.
- Unknown command 0x7F in IDLE -> one err pulse; busy stays 0. A following valid 01 load is accepted normally.
- rx_valid=1 with byte 0x55 during CALC -> one err pulse; results unchanged vs. the first test.
- Transmitter model holds tx_busy high for 20 cycles per byte. Check that each tx_start comes only after tx_busy has fallen, that tx_data is stable while busy, and that no start pulse is lost or duplicated.
- Assert rst during WAIT_LO of the 2nd element -> all outputs are 0 on the next edge and state=IDLE. A fresh load + compute then gives correct results from zeroed matrices (A unloaded ⇒ C=0).
- N=3, A=B=all 0xFF -> every element is 195075, sent as 02 FA 03. With MATMUL_SIGNED_EN (DW=8, value -1) every element is 3, sent as 00 00 03.
